// File: rtl/ms_collector_pkg.sv
// Shared types and sizing helpers for the slave-input collector.
package ms_collector_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    function automatic int res_w(input int data_w, input int num_ch);
        return data_w + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/ms_timeout_ctr.sv
// Per-channel wait counter; expire is high in the last allowed wait cycle.
module ms_timeout_ctr #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            // Timeout disabled: the collector waits forever on each channel.
            logic unused;
            assign unused = clk ^ rst ^ clr ^ inc;
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (inc) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expire = (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/ms_slave_collector.sv
// Round-robin collector: sums one word per slave channel per round,
// skipping channels whose sync does not arrive in time.
module ms_slave_collector
    import ms_collector_pkg::*;
#(
    parameter  int NUM_CH  = 3,
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 8,
    localparam int RES_W   = res_w(DATA_W, NUM_CH),
    localparam int CHW     = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] s_in,
    input  logic [NUM_CH-1:0]        s_in_sync,
    input  logic                     enable,
    output logic                     busy,
    output logic [CHW-1:0]           cur_ch,
    output logic [RES_W-1:0]         result,
    output logic                     result_valid,
    output logic [NUM_CH-1:0]        timeout_err
);

    state_e              state_q, state_d;
    logic [CHW-1:0]      ch_q, ch_d;
    logic [RES_W-1:0]    acc_q, acc_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic [NUM_CH-1:0]   terr_q, terr_d;
    logic                rv_q, rv_d;

    logic                tmo_clr;
    logic                tmo_inc;
    logic                tmo_exp;
    logic [DATA_W-1:0]   sel_w;
    logic [RES_W-1:0]    sel_x;
    logic [RES_W-1:0]    acc_n;
    logic [NUM_CH-1:0]   err_n;
    logic                adv;

    ms_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .inc    (tmo_inc),
        .expire (tmo_exp)
    );

    assign sel_w = s_in[ch_q*DATA_W +: DATA_W];
    assign sel_x = {{(RES_W-DATA_W){sel_w[DATA_W-1]}}, sel_w};

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        acc_d   = acc_q;
        err_d   = err_q;
        res_d   = res_q;
        terr_d  = terr_q;
        rv_d    = 1'b0;
        tmo_clr = 1'b1;
        tmo_inc = 1'b0;
        acc_n   = acc_q;
        err_n   = err_q;
        adv     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = COLLECT;
                    ch_d    = '0;
                    acc_d   = '0;
                    err_d   = '0;
                end
            end
            COLLECT: begin
                if (s_in_sync[ch_q]) begin
                    acc_n = acc_q + sel_x;
                    adv   = 1'b1;
                end else if (tmo_exp) begin
                    err_n[ch_q] = 1'b1;
                    adv         = 1'b1;
                end else begin
                    tmo_clr = 1'b0;
                    tmo_inc = 1'b1;
                end

                if (adv) begin
                    if (ch_q == CHW'(NUM_CH - 1)) begin
                        // Round end publishes the totals and restarts or parks.
                        res_d   = acc_n;
                        terr_d  = err_n;
                        rv_d    = 1'b1;
                        ch_d    = '0;
                        acc_d   = '0;
                        err_d   = '0;
                        state_d = enable ? COLLECT : IDLE;
                    end else begin
                        ch_d  = ch_q + CHW'(1);
                        acc_d = acc_n;
                        err_d = err_n;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            acc_q   <= '0;
            err_q   <= '0;
            res_q   <= '0;
            terr_q  <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            res_q   <= res_d;
            terr_q  <= terr_d;
            rv_q    <= rv_d;
        end
    end

    assign busy         = (state_q == COLLECT);
    assign cur_ch       = ch_q;
    assign result       = res_q;
    assign result_valid = rv_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_ms_slave_collector.sv
// Randomized round-level bench for ms_slave_collector.
module tb_ms_slave_collector;

    localparam int NUM_CH  = 3;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 8;
    localparam int RES_W   = DATA_W + $clog2(NUM_CH);
    localparam int CHW     = $clog2(NUM_CH);

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] s_in;
    logic [NUM_CH-1:0]        s_in_sync;
    logic                     enable;
    logic                     busy;
    logic [CHW-1:0]           cur_ch;
    logic [RES_W-1:0]         result;
    logic                     result_valid;
    logic [NUM_CH-1:0]        timeout_err;

    int     n_cmp = 0;
    int     n_err = 0;
    longint held_res = 0;
    longint held_err = 0;
    bit     idle = 1'b1;

    ms_slave_collector #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_in         (s_in),
        .s_in_sync    (s_in_sync),
        .enable       (enable),
        .busy         (busy),
        .cur_ch       (cur_ch),
        .result       (result),
        .result_valid (result_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic sy, input int v);
        s_in[c*DATA_W +: DATA_W] = DATA_W'(v);
        s_in_sync[c] = sy;
    endtask

    // Random junk on every channel except the one being awaited.
    task automatic noise_except(input int c, input bit on);
        logic [NUM_CH-1:0] m;
        s_in = NUM_CH*DATA_W'($urandom);
        m = NUM_CH'($urandom);
        m[c] = 1'b0;
        s_in_sync = on ? m : '0;
    endtask

    task automatic post(input int c, input bit adv, input bit last,
                        input bit cont, input longint sum,
                        input longint mask);
        bit fin;
        fin = adv && last;
        chk("result_valid", result_valid, fin);
        chk("busy", busy, !(fin && !cont));
        chk("cur_ch", cur_ch, adv ? (last ? 0 : c + 1) : c);
        if (fin) begin
            held_res = sum;
            held_err = mask;
        end
        chk("result", $signed(result), held_res);
        chk("timeout_err", timeout_err, held_err);
    endtask

    task automatic start();
        enable = 1'b1;
        s_in_sync = '0;
        tick();
        chk("start_busy", busy, 1);
        chk("start_ch", cur_ch, 0);
        chk("start_rv", result_valid, 0);
    endtask

    // k[c] = idle cycles before channel c syncs; k >= TIMEOUT never syncs.
    task automatic do_round(input int v0, input int v1, input int v2,
                            input int k0, input int k1, input int k2,
                            input bit cont, input bit noise);
        int v[NUM_CH];
        int k[NUM_CH];
        longint sum;
        longint mask;
        v = '{v0, v1, v2};
        k = '{k0, k1, k2};
        sum = 0;
        mask = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (k[c] < TIMEOUT) sum += v[c];
            else mask |= longint'(1) << c;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            bit tmo;
            int low;
            bit last;
            tmo  = (k[c] >= TIMEOUT);
            low  = tmo ? TIMEOUT : k[c];
            last = (c == NUM_CH - 1);
            for (int w = 0; w < low; w++) begin
                bit skip;
                skip = tmo && (w == low - 1);
                noise_except(c, noise);
                enable = (last && skip) ? cont : 1'($urandom);
                tick();
                post(c, skip, last, cont, sum, mask);
            end
            if (!tmo) begin
                noise_except(c, noise);
                set_ch(c, 1'b1, v[c]);
                enable = last ? cont : 1'($urandom);
                tick();
                post(c, 1'b1, last, cont, sum, mask);
            end
        end
        s_in_sync = '0;
        enable = cont;
        idle = !cont;
    endtask

    initial begin
        rst = 1'b1;
        s_in = '0;
        s_in_sync = '0;
        enable = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ch", cur_ch, 0);
        chk("rst_res", result, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_err", timeout_err, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        start();
        do_round(5, -2, 10, 0, 0, 0, 1'b0, 1'b0);
        tick();
        chk("idle_after", busy, 0);
        chk("rv_pulse", result_valid, 0);

        start();
        do_round(1, 2, 3, 3, 1, 0, 1'b0, 1'b1);

        start();
        do_round(4, 55, -7, 0, TIMEOUT, 0, 1'b0, 1'b0);

        start();
        do_round(1, 2, 3, 0, 0, 0, 1'b1, 1'b0);
        do_round(1, 2, 3, 0, 0, 0, 1'b1, 1'b0);
        do_round(1, 2, 3, 0, 0, 0, 1'b0, 1'b0);

        start();
        do_round(-128, -128, -128, 0, 0, 0, 1'b0, 1'b0);

        start();
        do_round(9, 9, 9, TIMEOUT, TIMEOUT + 1, TIMEOUT, 1'b0, 1'b1);

        for (int r = 0; r < 30; r++) begin
            bit cont;
            cont = (r == 29) ? 1'b0 : 1'($urandom);
            if (idle) start();
            do_round($signed(8'($urandom)), $signed(8'($urandom)),
                     $signed(8'($urandom)),
                     $urandom_range(0, TIMEOUT + 1),
                     $urandom_range(0, TIMEOUT + 1),
                     $urandom_range(0, TIMEOUT + 1),
                     cont, 1'($urandom));
        end

        start();
        do_round(5, -2, 10, 0, 0, 0, 1'b0, 1'b0);
        start();
        set_ch(0, 1'b1, 7);
        tick();
        s_in_sync = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ch", cur_ch, 0);
        chk("arst_res", result, 0);
        chk("arst_rv", result_valid, 0);
        chk("arst_err", timeout_err, 0);
        #3;
        rst = 1'b0;
        held_res = 0;
        held_err = 0;
        enable = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        start();
        do_round(1, 2, 3, 0, 2, 0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
